module_codificador_hamming_tx: RTL and testbench
================================================

Name: module_codificador_hamming_tx

Overview:
Transmit end of the Hamming(7,4) link. Accepts a 4-bit data nibble via a valid/ready handshake and encodes it into a 7-bit codeword, ordered [i3,i2,i1,c2,i0,c1,c0] so the receiver's syndrome [p2,p1,p0] equals the flipped bit position. Optionally injects a single-bit error, then serializes the codeword as a UART-style frame. Also presents the codeword in parallel for loopback into the error detector.

Parameters:
CICLOS_POR_BIT, 4, clock cycles each serial bit is held (legal range >= 1).

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous, active-low reset
datos  input  4  data nibble [i3,i2,i1,i0]
pos_error  input  3  error-injection position; 0 = none, 1..7 = flip codeword bit (pos_error-1)
dato_valido  input  1  request to send datos
listo  output  1  block can accept a nibble (high only in IDLE)
codigo  output  7  latched transmitted codeword [i3,i2,i1,c2,i0,c1,c0], error already applied
codigo_valido  output  1  one-cycle pulse when codigo updates
tx_serial  output  1  serial line, idles high
ocupado  output  1  high while a frame is in progress
tx_fin  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset (async assert, sync release) sets: state IDLE, tx_serial=1, listo=1, ocupado=0, codigo=0, codigo_valido=0, tx_fin=0, and clears all counters. Reset mid-frame aborts the frame immediately and drives the line high.
- Encoding:
  - c0 = i0^i1^i3
  - c1 = i0^i2^i3
  - c2 = i1^i2^i3
- Error injection: if pos_error != 0, XOR codeword bit (pos_error-1) with 1.
- Handshake: a transfer occurs when dato_valido && listo on a rising edge. datos and pos_error are sampled only on that edge. Inputs are ignored while ocupado.
- Latency: on the cycle after acceptance, codigo holds the new codeword, codigo_valido=1 for exactly one cycle, the state is START, and tx_serial=0.
- Frame order: start bit (0), then codigo[0] through codigo[6] LSB-first, then stop bit (1). Each bit lasts CICLOS_POR_BIT cycles, so a frame is 9*CICLOS_POR_BIT cycles.
- FSM:
  - IDLE: tx_serial=1, listo=1; on transfer go to START.
  - START: go to DATOS after CICLOS_POR_BIT cycles.
  - DATOS: a 3-bit index counts 0 to 6; after the 7th bit go to STOP.
  - STOP: tx_serial=1; tx_fin pulses in the final cycle; then go to IDLE.
- ocupado = (state != IDLE). listo = !ocupado && rst_n released.
- Back-to-back: at least one IDLE cycle separates frames. The earliest next acceptance is the cycle after tx_fin.
- codigo holds its value until the next accepted transfer.
- Counter widths: $clog2(CICLOS_POR_BIT) with a minimum of 1 bit. With CICLOS_POR_BIT=1, each bit lasts exactly one cycle.

Decomposition:
- Shared package pkg_hamming holds:
  - the FSM state enum (IDLE, START, DATOS, STOP)
  - bit-position constants for the codeword layout
  - an encode function that returns the 7-bit codeword from 4 data bits, reused by benches and the detector's reference model
- One natural sub-module, module_codificador_hamming: purely combinational encode plus error injection (datos, pos_error -> codeword).
- The FSM, serializer and handshake live in the top block.

Test Plan:
1. Reset held, then released with dato_valido=0 -> tx_serial=1, listo=1, codigo=7'b0000000 and no pulses for 20 cycles.
2. datos=4'b1011, pos_error=0 -> codigo=7'b1010101 and a codigo_valido pulse on the cycle after the transfer. Line carries 0, then 1,0,1,0,1,0,1, then 1, each bit held 4 cycles; tx_fin pulses at cycle 36. Detector syndrome is 000.
3. datos=4'b1011, pos_error=3 -> codigo=7'b1010001. Looped into the detector, syndrome=011 and the error bit is flagged.
4. datos=4'b0001 then 4'b1111, with dato_valido held high -> codigos 7'b0000111 and 7'b1111111. The second acceptance occurs exactly 2 cycles after tx_fin, and datos changes mid-frame are ignored.
5. rst_n asserted during DATOS bit 3 -> tx_serial goes to 1 asynchronously and the state is IDLE. After release, a new frame with datos=4'b0000 sends codigo=7'b0000000.
6. CICLOS_POR_BIT=1 and sweep of all 16 nibbles x 8 pos_error values -> codigo matches the pkg_hamming encode function with the error applied, and each frame lasts 9 cycles.

Source files
------------

// File: rtl/pkg_hamming.sv
// Shared definitions for the Hamming(7,4) link.
// - estado_t  : transmitter FSM states
// - POS_*     : bit positions inside the codeword [i3,i2,i1,c2,i0,c1,c0]
//               (bit k holds Hamming position k+1, so a receiver syndrome
//               [p2,p1,p0] names the flipped position directly)
// - codificar : 4 data bits -> 7-bit error-free codeword
package pkg_hamming;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATOS = 2'd2,
    STOP  = 2'd3
  } estado_t;

  localparam int BITS_DATO   = 4;
  localparam int BITS_CODIGO = 7;

  localparam int POS_C0 = 0;
  localparam int POS_C1 = 1;
  localparam int POS_I0 = 2;
  localparam int POS_C2 = 3;
  localparam int POS_I1 = 4;
  localparam int POS_I2 = 5;
  localparam int POS_I3 = 6;

  // Index of the last data bit on the serial line.
  localparam logic [2:0] IDX_ULTIMO = 3'd6;

  function automatic logic [BITS_CODIGO-1:0] codificar(input logic [BITS_DATO-1:0] d);
    logic [BITS_CODIGO-1:0] cw;
    cw         = '0;
    cw[POS_I0] = d[0];
    cw[POS_I1] = d[1];
    cw[POS_I2] = d[2];
    cw[POS_I3] = d[3];
    cw[POS_C0] = d[0] ^ d[1] ^ d[3];
    cw[POS_C1] = d[0] ^ d[2] ^ d[3];
    cw[POS_C2] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

endpackage

// File: rtl/module_codificador_hamming.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// Ports:
//   datos     in  4  data nibble [i3,i2,i1,i0]
//   pos_error in  3  0 = no error, 1..7 = flip codeword bit (pos_error-1)
//   codigo    out 7  codeword [i3,i2,i1,c2,i0,c1,c0] with the error applied
module module_codificador_hamming
  import pkg_hamming::*;
(
  input  logic [BITS_DATO-1:0]   datos,
  input  logic [2:0]             pos_error,
  output logic [BITS_CODIGO-1:0] codigo
);

  logic [BITS_CODIGO-1:0] mascara;

  always_comb begin
    mascara = '0;
    if (pos_error != 3'd0)
      mascara = 7'b000_0001 << (pos_error - 3'd1);
  end

  assign codigo = codificar(datos) ^ mascara;

endmodule

// File: rtl/module_codificador_hamming_tx.sv
// Transmit end of the Hamming(7,4) link: handshake, encode (+ error
// injection) and UART-style serialization of the codeword.
// Frame: start(0), codigo[0..6] LSB-first, stop(1); each bit lasts
// CICLOS_POR_BIT cycles.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   datos          in  4  data nibble
//   pos_error      in  3  error-injection position (0 = none)
//   dato_valido    in  1  request to send datos
//   listo          out 1  ready to accept (IDLE only)
//   codigo         out 7  latched transmitted codeword
//   codigo_valido  out 1  one-cycle pulse when codigo updates
//   tx_serial      out 1  serial line, idles high
//   ocupado        out 1  frame in progress
//   tx_fin         out 1  pulse in the last cycle of the stop bit
module module_codificador_hamming_tx
  import pkg_hamming::*;
#(
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BITS_DATO-1:0]   datos,
  input  logic [2:0]             pos_error,
  input  logic                   dato_valido,
  output logic                   listo,
  output logic [BITS_CODIGO-1:0] codigo,
  output logic                   codigo_valido,
  output logic                   tx_serial,
  output logic                   ocupado,
  output logic                   tx_fin
);

  localparam int CW = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(CICLOS_POR_BIT - 1);

  estado_t                estado, estado_sig;
  logic [CW-1:0]          cnt, cnt_sig;
  logic [2:0]             idx, idx_sig;
  logic [BITS_CODIGO-1:0] codigo_sig, palabra;
  logic                   valido_sig, tx_sig, fin_sig;
  logic                   fin_bit;

  module_codificador_hamming u_cod (
    .datos     (datos),
    .pos_error (pos_error),
    .codigo    (palabra)
  );

  assign fin_bit = (cnt == CNT_ULTIMO);
  assign ocupado = (estado != IDLE);
  assign listo   = (estado == IDLE);

  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    idx_sig    = idx;
    codigo_sig = codigo;
    valido_sig = 1'b0;
    unique case (estado)
      IDLE: begin
        if (dato_valido) begin
          estado_sig = START;
          cnt_sig    = '0;
          codigo_sig = palabra;
          valido_sig = 1'b1;
        end
      end
      START: begin
        if (fin_bit) begin
          estado_sig = DATOS;
          cnt_sig    = '0;
          idx_sig    = '0;
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      DATOS: begin
        if (fin_bit) begin
          cnt_sig = '0;
          if (idx == IDX_ULTIMO) estado_sig = STOP;
          else                   idx_sig    = idx + 3'd1;
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      STOP: begin
        if (fin_bit) begin
          estado_sig = IDLE;
          cnt_sig    = '0;
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      default: estado_sig = IDLE;
    endcase
  end

  // Line level and tx_fin are derived from the next state so that both
  // leave a flop: no combinational glitches on the serial line.
  always_comb begin
    tx_sig = 1'b1;
    unique case (estado_sig)
      START:   tx_sig = 1'b0;
      DATOS:   tx_sig = codigo_sig[idx_sig];
      default: tx_sig = 1'b1;
    endcase
    fin_sig = (estado_sig == STOP) && (cnt_sig == CNT_ULTIMO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      codigo        <= '0;
      codigo_valido <= 1'b0;
      tx_serial     <= 1'b1;
      tx_fin        <= 1'b0;
    end else begin
      estado        <= estado_sig;
      cnt           <= cnt_sig;
      idx           <= idx_sig;
      codigo        <= codigo_sig;
      codigo_valido <= valido_sig;
      tx_serial     <= tx_sig;
      tx_fin        <= fin_sig;
    end
  end

endmodule

// File: tb/tb_module_codificador_hamming_tx.sv
// Scoreboard bench: unit 0 runs with 4 cycles per bit, unit 1 with 1.
module tb_module_codificador_hamming_tx;

  typedef struct {
    logic [6:0] cw;
    int         pe;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n   [2];
  logic [3:0] datos   [2];
  logic [2:0] pe      [2];
  logic       dv      [2];
  logic       listo   [2];
  logic [6:0] codigo  [2];
  logic       cv      [2];
  logic       tx      [2];
  logic       ocu     [2];
  logic       fin     [2];

  int checks = 0, failures = 0, cyc = 0;
  int last_fin [2] = '{-100, -100};
  int aborted  [2] = '{0, 0};
  exp_t qa[$], qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  module_codificador_hamming_tx #(.CICLOS_POR_BIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .datos(datos[0]), .pos_error(pe[0]),
    .dato_valido(dv[0]), .listo(listo[0]), .codigo(codigo[0]),
    .codigo_valido(cv[0]), .tx_serial(tx[0]), .ocupado(ocu[0]), .tx_fin(fin[0]));

  module_codificador_hamming_tx #(.CICLOS_POR_BIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .datos(datos[1]), .pos_error(pe[1]),
    .dato_valido(dv[1]), .listo(listo[1]), .codigo(codigo[1]),
    .codigo_valido(cv[1]), .tx_serial(tx[1]), .ocupado(ocu[1]), .tx_fin(fin[1]));

  // Reference model: classic Hamming layout, 1-based positions 1..7;
  // parity at positions 1,2,4 covers every position sharing that bit.
  function automatic logic [6:0] model_cw(input logic [3:0] d, input int perr);
    logic [7:1] p;
    int di;
    p  = '0;
    di = 0;
    for (int k = 1; k <= 7; k++)
      if ((k & (k - 1)) != 0) begin p[k] = d[di]; di++; end
    for (int pb = 1; pb <= 4; pb = pb * 2)
      for (int k = 1; k <= 7; k++)
        if ((k & pb) != 0 && k != pb) p[pb] = p[pb] ^ p[k];
    if (perr != 0) p[perr] = ~p[perr];
    return p;
  endfunction

  function automatic int synd(input logic [6:0] c);
    int s = 0;
    for (int k = 1; k <= 7; k++) if (c[k-1]) s = s ^ k;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input int u, input exp_t e);
    if (u == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  // Monitor: checks each frame presented by unit u.
  task automatic mon(input int u, input int cpb);
    exp_t e;
    logic [8:0] frm;
    int bad_line, bad_ctl, nfin, fin_at;
    bit abort, have;
    forever begin
      @(negedge clk);
      if (rst_n[u] && fin[u]) begin
        checks++; failures++;
        $display("FAIL stray_tx_fin unit=%0d actual=1 required=0", u);
      end
      if (rst_n[u] && cv[u]) begin
        have = (u == 0) ? (qa.size() > 0) : (qb.size() > 0);
        if (!have) begin
          checks++; failures++;
          $display("FAIL sb_unexpected unit=%0d codigo=%b required=no frame", u, codigo[u]);
          continue;
        end
        e = (u == 0) ? qa.pop_front() : qb.pop_front();
        chk($sformatf("codigo_u%0d", u), 32'(codigo[u]), 32'(e.cw));
        chk($sformatf("syndrome_u%0d", u), 32'(synd(codigo[u])), 32'(e.pe));
        if (e.b2b) chk("b2b_gap", 32'(cyc - last_fin[u]), 32'd2);
        frm = {1'b1, e.cw, 1'b0};
        bad_line = 0; bad_ctl = 0; nfin = 0; fin_at = -1; abort = 0;
        for (int k = 0; k < 9 * cpb; k++) begin
          if (k > 0) begin
            @(negedge clk);
            if (!rst_n[u]) begin abort = 1; break; end
          end
          if (tx[u] !== frm[k / cpb]) bad_line++;
          if (ocu[u] !== 1'b1 || listo[u] !== 1'b0) bad_ctl++;
          if (k > 0 && cv[u] !== 1'b0) bad_ctl++;
          if (fin[u]) begin nfin++; fin_at = k; last_fin[u] = cyc; end
        end
        if (abort) aborted[u]++;
        else begin
          chk($sformatf("line_u%0d", u), 32'(bad_line), 32'd0);
          chk($sformatf("ctl_u%0d", u), 32'(bad_ctl), 32'd0);
          chk($sformatf("fin_cnt_u%0d", u), 32'(nfin), 32'd1);
          chk($sformatf("fin_at_u%0d", u), 32'(fin_at), 32'(9 * cpb - 1));
        end
      end
    end
  endtask

  initial mon(0, 4);
  initial mon(1, 1);

  // Waits for listo (scrambling datos meanwhile if valid is held), then
  // presents the request so the next rising edge accepts it.
  task automatic send(input int u, input logic [3:0] d, input logic [2:0] perr,
                      input bit hold, input bit b2b);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!listo[u] && t < 400) begin
      if (dv[u]) datos[u] = 4'($urandom);
      @(negedge clk);
      t++;
    end
    if (!listo[u]) begin
      checks++; failures++;
      $display("FAIL listo_timeout unit=%0d actual=0 required=1", u);
      return;
    end
    datos[u] = d; pe[u] = perr; dv[u] = 1'b1;
    e.cw = model_cw(d, int'(perr)); e.pe = int'(perr); e.b2b = b2b;
    push(u, e);
    @(posedge clk);
    @(negedge clk);
    if (hold) datos[u] = 4'($urandom);
    else      dv[u] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int bad;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; dv[u] = 1'b0; datos[u] = '0; pe[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_tx", 32'(tx[u]), 32'd1);
      chk("rst_listo", 32'(listo[u]), 32'd1);
      chk("rst_codigo", 32'(codigo[u]), 32'd0);
      chk("rst_pulses", 32'({cv[u], fin[u], ocu[u]}), 32'd0);
    end
    #2;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    for (int u = 0; u < 2; u++) begin
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (tx[u] !== 1'b1 || listo[u] !== 1'b1 || codigo[u] !== 7'd0 ||
            cv[u] !== 1'b0 || fin[u] !== 1'b0 || ocu[u] !== 1'b0) bad++;
      end
      chk("idle20", 32'(bad), 32'd0);
    end

    // Test-plan frames for unit 0 (4 cycles per bit).
    send(0, 4'b1011, 3'd0, 0, 0);
    send(0, 4'b1011, 3'd3, 0, 0);
    send(0, 4'b0001, 3'd0, 1, 0);
    send(0, 4'b1111, 3'd0, 0, 1);
    for (int i = 0; i < 6; i++) send(0, 4'($urandom), 3'($urandom), 0, 0);

    // Reset during data bit 3: index 0 is the first START cycle.
    send(0, 4'b1011, 3'd0, 0, 0);
    repeat (17) @(negedge clk);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx[0]), 32'd1);
    chk("async_rst_listo", 32'(listo[0]), 32'd1);
    chk("async_rst_ocupado", 32'(ocu[0]), 32'd0);
    chk("async_rst_codigo", 32'(codigo[0]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n[0] = 1'b1;
    send(0, 4'b0000, 3'd0, 0, 0);

    // Unit 1: full sweep plus random frames.
    for (int d = 0; d < 16; d++)
      chk("pkg_codificar", 32'(pkg_hamming::codificar(4'(d))), 32'(model_cw(4'(d), 0)));
    for (int d = 0; d < 16; d++)
      for (int p = 0; p < 8; p++) send(1, 4'(d), 3'(p), 0, 0);
    for (int i = 0; i < 20; i++) send(1, 4'($urandom), 3'($urandom_range(7, 0)), 0, 0);

    bad = 0;
    while ((qa.size() != 0 || qb.size() != 0 || ocu[0] || ocu[1]) && bad < 1000) begin
      @(negedge clk);
      bad++;
    end
    chk("drain", 32'(qa.size() + qb.size()), 32'd0);
    chk("aborted_frames", 32'(aborted[0]), 32'd1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
